// File: rtl/demux_1to4_stream.sv
// 1-to-4 stream demultiplexer: routes one valid/ready input to one of four
// single-entry output channels selected by in_sel, counting accepted words.
module demux_1to4_stream #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [CNT_W-1:0]     accept_cnt
);

  localparam int unsigned NCH = 4;

  logic                accept;
  logic [4*WIDTH-1:0]  data_nxt;
  logic [NCH-1:0]      valid_nxt;
  logic [CNT_W-1:0]    cnt_nxt;

  // Selected slot is free or draining this cycle; enable is active-low.
  assign in_ready = !enable && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  // Per-channel refill has priority over drain so a same-edge drain+refill keeps valid high.
  always_comb begin
    data_nxt  = out_data;
    valid_nxt = out_valid;
    cnt_nxt   = accept_cnt + CNT_W'(accept);
    for (int i = 0; i < NCH; i++) begin
      if (accept && (in_sel == 2'(i))) begin
        data_nxt[i*WIDTH +: WIDTH] = in_data;
        valid_nxt[i]               = 1'b1;
      end else if (out_ready[i]) begin
        valid_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      out_data   <= '0;
      out_valid  <= '0;
      accept_cnt <= '0;
    end else begin
      out_data   <= data_nxt;
      out_valid  <= valid_nxt;
      accept_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed self-checking bench for demux_1to4_stream with hand-computed expectations.
module tb_demux_1to4_stream;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned CNT_W = 8;

  logic               clk = 1'b0;
  logic               reset_p;
  logic               enable;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [CNT_W-1:0]   accept_cnt;

  int ncmp = 0;
  int nerr = 0;

  demux_1to4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .enable     (enable),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ch(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
  endtask

  initial begin
    logic [WIDTH-1:0] vals [4];
    logic [WIDTH-1:0] d;
    vals[0] = 2'b01; vals[1] = 2'b10; vals[2] = 2'b11; vals[3] = 2'b00;

    reset_p = 1'b1; enable = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
    out_ready = 4'hF;
    step();
    reset_p = 1'b0;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_cnt", 32'(accept_cnt), 32'd0);

    // Basic routing: one word per channel, each pulses for one cycle
    for (int i = 0; i < 4; i++) begin
      send(2'(i), vals[i]);
      #1 check("basic_rdy", 32'(in_ready), 32'd1);
      step();
      check("basic_valid", 32'(out_valid), 32'(4'b0001 << i));
      check("basic_data", 32'(ch(i)), 32'(vals[i]));
    end
    in_valid = 1'b0;
    step();
    check("basic_drained", 32'(out_valid), 32'h0);
    check("basic_cnt", 32'(accept_cnt), 32'd4);

    // Backpressure on b, then drain and refill on the same edge
    out_ready = 4'b1101;
    send(2'd1, 2'b11);
    #1 check("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    send(2'd1, 2'b01);
    #1 check("bp_rdy2", 32'(in_ready), 32'd0);
    step();
    check("bp_hold_v", 32'(out_valid), 32'b0010);
    check("bp_hold_d", 32'(ch(1)), 32'b11);
    check("bp_cnt", 32'(accept_cnt), 32'd5);
    out_ready = 4'b1111;
    #1 check("bp_rdy3", 32'(in_ready), 32'd1);
    step();
    check("bp_refill_v", 32'(out_valid), 32'b0010);
    check("bp_refill_d", 32'(ch(1)), 32'b01);
    check("bp_cnt2", 32'(accept_cnt), 32'd6);
    in_valid = 1'b0;
    step();
    check("bp_drain", 32'(out_valid), 32'h0);

    // Independence: a stalled and full does not block c
    out_ready = 4'b1110;
    send(2'd0, 2'b11);
    step();
    send(2'd0, 2'b01);
    #1 check("ind_a_rdy", 32'(in_ready), 32'd0);
    send(2'd2, 2'b10);
    #1 check("ind_c_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("ind_valid", 32'(out_valid), 32'b0101);
    check("ind_c_data", 32'(ch(2)), 32'b10);
    check("ind_a_data", 32'(ch(0)), 32'b11);
    check("ind_cnt", 32'(accept_cnt), 32'd8);
    step();
    check("ind_valid2", 32'(out_valid), 32'b0001);
    check("ind_a_data2", 32'(ch(0)), 32'b11);

    // Enable: preload b, stall input, b still drains
    out_ready = 4'b0001;
    send(2'd1, 2'b01);
    step();
    check("en_pre_v", 32'(out_valid), 32'b0010);
    check("en_pre_cnt", 32'(accept_cnt), 32'd9);
    enable = 1'b1;
    send(2'd3, 2'b10);
    #1 check("en_rdy0", 32'(in_ready), 32'd0);
    step();
    check("en_v0", 32'(out_valid), 32'b0010);
    out_ready = 4'b1011;
    #1 check("en_rdy1", 32'(in_ready), 32'd0);
    step();
    check("en_v1", 32'(out_valid), 32'b0000);
    #1 check("en_rdy2", 32'(in_ready), 32'd0);
    step();
    check("en_cnt", 32'(accept_cnt), 32'd9);
    enable = 1'b0;
    #1 check("en_rdy3", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("en_d_v", 32'(out_valid), 32'b1000);
    check("en_d_data", 32'(ch(3)), 32'b10);
    check("en_cnt2", 32'(accept_cnt), 32'd10);
    step();
    check("en_drain", 32'(out_valid), 32'h0);

    // Reset mid-operation with a word offered on the reset edge
    out_ready = 4'b0000;
    send(2'd0, 2'b01);
    step();
    send(2'd2, 2'b11);
    step();
    check("mr_pre_v", 32'(out_valid), 32'b0101);
    check("mr_pre_cnt", 32'(accept_cnt), 32'd12);
    reset_p = 1'b1;
    send(2'd1, 2'b10);
    step();
    reset_p = 1'b0;
    in_valid = 1'b0;
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_data", 32'(out_data), 32'h0);
    check("mr_cnt", 32'(accept_cnt), 32'd0);
    step();
    check("mr_valid2", 32'(out_valid), 32'h0);
    check("mr_cnt2", 32'(accept_cnt), 32'd0);

    // Counter wrap over 256 accepts, rotating channels
    out_ready = 4'hF;
    for (int i = 0; i < 256; i++) begin
      d = 2'((i * 3 + 1) % 4);
      send(2'(i % 4), d);
      if (i == 255) check("wrap_pre", 32'(accept_cnt), 32'd255);
      step();
      check("wrap_v", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      check("wrap_d", 32'(ch(i % 4)), 32'(d));
    end
    in_valid = 1'b0;
    step();
    check("wrap_cnt", 32'(accept_cnt), 32'd0);
    check("wrap_drain", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/demux_1to4_stream.md
Name: demux_1to4_stream

Overview:
- Routes a single WIDTH-bit input stream to one of four output channels, a..d, selected by in_sel.
- Each channel has a one-entry holding register with its own valid/ready handshake.
- It is the distribution-side counterpart of the team's 4-to-1 mux. It uses the same sel encoding (00=a, 01=b, 10=c, 11=d) and the same active-low enable convention.
- It sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 2, data width of the input and of each output channel.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_p  input  1  synchronous, active-high reset.
- enable  input  1  active-low enable. 0 = routing allowed; 1 = input stalled (in_ready forced 0).
- in_data  input  WIDTH  input payload.
- in_sel  input  2  destination channel: 00=a, 01=b, 10=c, 11=d.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle. Combinational.
- out_data  output  4*WIDTH  channel data, packed: a=[WIDTH-1:0], b next, c next, d=[4*WIDTH-1:3*WIDTH]. Registered.
- out_valid  output  4  per-channel valid, bit0=a .. bit3=d. Registered.
- out_ready  input  4  per-channel consumer ready, bit0=a .. bit3=d.
- accept_cnt  output  CNT_W  number of accepted input transfers. Registered.

Behaviour:
- Reset: synchronous, applied on a rising edge with reset_p=1. On reset, out_data=0, out_valid=4'b0000 and accept_cnt=0; any held words are discarded. Reset overrides all simultaneous transfers, including in the middle of an operation.
- Handshake rules (AXI-style):
  - A transfer occurs on an edge where valid=1 and ready=1.
  - The producer holds in_data and in_sel stable while in_valid=1 and in_ready=0.
  - The block holds out_data[i] stable while out_valid[i]=1 and out_ready[i]=0.
- in_ready = (enable==0) && (out_valid[in_sel]==0 || out_ready[in_sel]==1).
  - It is evaluated for the current in_sel regardless of in_valid.
  - It never depends on the state of non-selected channels.
- Accept (in_valid && in_ready):
  - At the next edge, the selected channel loads in_data and its out_valid is set to 1. Latency from input to output is 1 cycle.
  - accept_cnt increments by 1 and wraps from 2^CNT_W-1 to 0 with no flag.
- Drain (out_valid[i] && out_ready[i]): at the next edge, out_valid[i] clears, unless the same channel is refilled on that edge.
- Simultaneous drain and refill of the same channel: out_valid[i] stays 1 and out_data[i] takes the new word. Full throughput is one word per cycle per channel.
- Channels drain independently. A stalled channel blocks the input only while in_sel points at it. Other channels keep draining and accepting.
- After a drain, out_data[i] keeps its last value. Consumers ignore it while out_valid[i]=0.
- enable=1: no new words are accepted, but already-held words still drain normally. When enable returns to 0, acceptance resumes the same cycle.
- No reordering is possible: each channel holds at most one word.

Test Plan:
- Reset with all out_ready=1, then send 2'b01 to a, 2'b10 to b, 2'b11 to c, 2'b00 to d on consecutive cycles.
  - Each out_valid bit pulses for 1 cycle, one cycle after its accept, with matching data.
  - accept_cnt = 4.
- Backpressure: out_ready[b]=0, send 2'b11 then 2'b01 to b.
  - First is accepted; in_ready=0 on the second.
  - out_data b holds 2'b11.
  - Raising out_ready[b] drains 2'b11, and 2'b01 is accepted in that same cycle. out_valid[b] stays 1 and the next value is 2'b01.
- Independence: channel a stalled and full, send 2'b10 to c.
  - in_ready=1 and c delivers 2'b10.
  - out_valid[a] remains 1 with unchanged data.
- Enable: enable=1 with in_valid=1 and sel=d.
  - in_ready=0 for all cycles.
  - A pre-loaded word in b still drains when out_ready[b]=1.
  - With enable=0, the d word is accepted on the next cycle.
- Reset mid-operation: channels a and c full, reset_p=1 for one edge, then in_valid=1 in the same cycle.
  - After the edge, out_valid=0000, out_data=0 and accept_cnt=0.
  - Nothing is accepted on that edge.
- Counter wrap: 256 accepted transfers with CNT_W=8 → accept_cnt returns to 0. Data on all four channels stays correct throughout.
